memory_writer: RTL and testbench

- Producer-side counterpart to the memory reader in the dotProductFifo path.
- Accepts a stream of vector elements over a valid/ready handshake and writes exactly 2**ADDRESS_WIDTH words into the shared vector memory at consecutive addresses, starting at 0.
- Raises done_writing when the buffer is full and holds it until the reader signals done_reading, so a buffer is never overwritten before it has been consumed.

---
 rtl/memory_writer.sv | 98 +++++++++
 tb/tb_memory_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_writer.sv
// memory_writer: fills the shared vector memory with one buffer of 2**ADDRESS_WIDTH
// elements taken from a valid/ready stream. Once the buffer is full it holds
// done_writing until the reader reports that it has consumed the buffer.
module memory_writer #(
  parameter int ADDRESS_WIDTH = 3,
  parameter int DATA_WIDTH    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     startLoading,
  input  logic [DATA_WIDTH-1:0]    dataIn,
  input  logic                     dataValid,
  output logic                     dataReady,
  output logic [ADDRESS_WIDTH-1:0] wraddr,
  output logic [DATA_WIDTH-1:0]    wrdata,
  output logic                     wren,
  output logic [ADDRESS_WIDTH:0]   wordCount,
  output logic                     done_writing,
  input  logic                     done_reading
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE   = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   COUNT_ONE  = (ADDRESS_WIDTH + 1)'(1);
  localparam logic [ADDRESS_WIDTH:0]   COUNT_FULL = (ADDRESS_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pointer;

  // Fill FSM: every output is a register, so dataReady drops on the same edge
  // that accepts the last word and no extra beat can ever slip through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pointer      <= '0;
      dataReady    <= 1'b0;
      wraddr       <= '0;
      wrdata       <= '0;
      wren         <= 1'b0;
      wordCount    <= '0;
      done_writing <= 1'b0;
    end else begin
      wren <= 1'b0;
      case (state)
        IDLE: begin
          dataReady    <= 1'b0;
          done_writing <= 1'b0;
          if (startLoading) begin
            state     <= FILL;
            pointer   <= '0;
            wordCount <= '0;
            dataReady <= 1'b1;
          end
        end

        FILL: begin
          if (dataValid && dataReady) begin
            wraddr    <= pointer;
            wrdata    <= dataIn;
            wren      <= 1'b1;
            pointer   <= pointer + ADDR_ONE;
            wordCount <= wordCount + COUNT_ONE;
            if (pointer == LAST_ADDR) begin
              state        <= FULL;
              dataReady    <= 1'b0;
              done_writing <= 1'b1;
              pointer      <= '0;
              wordCount    <= COUNT_FULL;
            end
          end
        end

        FULL: begin
          dataReady    <= 1'b0;
          done_writing <= 1'b1;
          if (done_reading) begin
            state        <= IDLE;
            done_writing <= 1'b0;
            wordCount    <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          dataReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writer.sv
// tb_memory_writer: directed and randomized stimulus for memory_writer, checked
// cycle by cycle against a phase/count reference model of a buffer fill.
module tb_memory_writer;

  localparam int ADDRESS_WIDTH = 3;
  localparam int DATA_WIDTH    = 12;
  localparam int DEPTH         = 2 ** ADDRESS_WIDTH;

  localparam int PH_IDLE = 0;
  localparam int PH_FILL = 1;
  localparam int PH_FULL = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     startLoading = 1'b0;
  logic [DATA_WIDTH-1:0]    dataIn = '0;
  logic                     dataValid = 1'b0;
  logic                     dataReady;
  logic [ADDRESS_WIDTH-1:0] wraddr;
  logic [DATA_WIDTH-1:0]    wrdata;
  logic                     wren;
  logic [ADDRESS_WIDTH:0]   wordCount;
  logic                     done_writing;
  logic                     done_reading = 1'b0;

  int checks = 0;
  int errors = 0;

  int phase      = PH_IDLE;
  int accepted   = 0;
  int modelWren  = 0;
  int modelAddr  = 0;
  int modelData  = 0;

  int                    wrenCount = 0;
  logic [DATA_WIDTH-1:0] observedMem [DEPTH];

  memory_writer #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .startLoading(startLoading),
    .dataIn      (dataIn),
    .dataValid   (dataValid),
    .dataReady   (dataReady),
    .wraddr      (wraddr),
    .wrdata      (wrdata),
    .wren        (wren),
    .wordCount   (wordCount),
    .done_writing(done_writing),
    .done_reading(done_reading)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: a buffer is either idle, being filled with `accepted` words, or full.
  task automatic modelStep(input logic r, input logic s, input logic v,
                           input logic [DATA_WIDTH-1:0] d, input logic dr);
    if (r) begin
      phase     = PH_IDLE;
      accepted  = 0;
      modelWren = 0;
      modelAddr = 0;
      modelData = 0;
    end else begin
      modelWren = 0;
      if (phase == PH_IDLE) begin
        if (s) begin
          phase    = PH_FILL;
          accepted = 0;
        end
      end else if (phase == PH_FILL) begin
        if (v) begin
          modelWren = 1;
          modelAddr = accepted % DEPTH;
          modelData = int'(d);
          accepted  = accepted + 1;
          if (accepted == DEPTH) phase = PH_FULL;
        end
      end else begin
        if (dr) begin
          phase    = PH_IDLE;
          accepted = 0;
        end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("dataReady", 32'(dataReady), 32'(phase == PH_FILL));
    checkOutput("done_writing", 32'(done_writing), 32'(phase == PH_FULL));
    checkOutput("wren", 32'(wren), 32'(modelWren));
    checkOutput("wraddr", 32'(wraddr), 32'(modelAddr));
    checkOutput("wrdata", 32'(wrdata), 32'(modelData));
    checkOutput("wordCount", 32'(wordCount), 32'(accepted));
    if (wren === 1'b1) begin
      wrenCount++;
      observedMem[wraddr] = wrdata;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic [DATA_WIDTH-1:0] d, input logic dr);
    rst          = r;
    startLoading = s;
    dataValid    = v;
    dataIn       = d;
    done_reading = dr;
    @(posedge clk);
    modelStep(r, s, v, d, dr);
    #1;
    checkAll();
  endtask

  // Directed test plan followed by a randomized soak
  initial begin
    int nextData;

    // Reset with random inputs, then idle cycles: nothing becomes ready
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    DATA_WIDTH'($urandom), 1'($urandom_range(0, 1)));
    checkOutput("reset_wordCount", 32'(wordCount), 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), DATA_WIDTH'($urandom),
                    1'($urandom_range(0, 1)));
    checkOutput("idle_ready", 32'(dataReady), 32'd0);

    // Back-to-back fill with 1..8
    wrenCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= DEPTH; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, DATA_WIDTH'(i), 1'b0);
    checkOutput("b2b_count", 32'(wordCount), 32'(DEPTH));
    checkOutput("b2b_done", 32'(done_writing), 32'd1);
    checkOutput("b2b_ready", 32'(dataReady), 32'd0);
    checkOutput("b2b_strobes", 32'(wrenCount), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      checkOutput("b2b_mem", 32'(observedMem[i]), 32'(i + 1));

    // Release, then gapped fill with 10..17
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    wrenCount = 0;
    nextData  = 10;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1'b0, 1'b0, 1'b1, DATA_WIDTH'(nextData), 1'b0);
        nextData++;
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, DATA_WIDTH'($urandom), 1'b0);
      end
    end
    checkOutput("gap_strobes", 32'(wrenCount), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      checkOutput("gap_mem", 32'(observedMem[i]), 32'(i + 10));

    // Full hold-off: valid data is ignored while the reader is busy
    wrenCount = 0;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, DATA_WIDTH'(99), 1'b0);
    checkOutput("hold_strobes", 32'(wrenCount), 32'd0);
    checkOutput("hold_done", 32'(done_writing), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("release_done", 32'(done_writing), 32'd0);
    checkOutput("release_count", 32'(wordCount), 32'd0);

    // New fill; a start pulse after 3 words does not restart the pointer
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, DATA_WIDTH'(40), 1'b0);
    checkOutput("refill_addr0", 32'(wraddr), 32'd0);
    for (int i = 1; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, DATA_WIDTH'(40 + i), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, DATA_WIDTH'(43), 1'b0);
    checkOutput("midstart_addr", 32'(wraddr), 32'd3);
    for (int i = 4; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, DATA_WIDTH'(40 + i), 1'b0);

    // done_reading and startLoading together: start is dropped
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("simul_ready", 32'(dataReady), 32'd0);

    // Reset after 5 accepted words abandons the buffer
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, DATA_WIDTH'(200 + i), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, DATA_WIDTH'(255), 1'b0);
    checkOutput("midrst_count", 32'(wordCount), 32'd0);
    checkOutput("midrst_addr", 32'(wraddr), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, DATA_WIDTH'(77), 1'b0);
    checkOutput("postrst_addr", 32'(wraddr), 32'd0);
    checkOutput("postrst_data", 32'(wrdata), 32'd77);

    // Randomized soak
    for (int i = 0; i < 600; i++)
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 2) != 0), DATA_WIDTH'($urandom),
                    1'($urandom_range(0, 5) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
